// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives instruction memory and registers each instruction with its PC
// toward decode over a valid/ready handshake. Define FETCH_PERF_EN to add the saturating fetch_count output.
module fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [ADDR_WIDTH-1:0]  instruction_address,
  input  logic [INSTR_WIDTH-1:0] instruction_data,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt_request,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] fetch_instruction,
  output logic [ADDR_WIDTH-1:0]  fetch_pc,
  output logic                   halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            fetch_count
`endif
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  fpc_q, fpc_d;
  logic                   accept;
  logic                   slotFree;

  assign accept   = valid_q & fetch_ready;
  assign slotFree = !valid_q | fetch_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    fpc_d   = fpc_q;
    case (state_q)
      BOOT: begin
        if (branch_taken) pc_d = branch_target;
        state_d = halt_request ? HALTED : FETCH;
      end
      FETCH: begin
        // Redirect flushes the output slot even if decode never took it.
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = halt_request ? HALTED : FETCH;
        end else if (halt_request) begin
          state_d = HALTED;
          if (accept) valid_d = 1'b0;
        end else if (slotFree) begin
          instr_d = instruction_data;
          fpc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(1);
        end
      end
      HALTED: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
    end
  end

  assign instruction_address = pc_q;
  assign fetch_valid         = valid_q;
  assign fetch_instruction   = instr_q;
  assign fetch_pc            = fpc_q;
  assign halted              = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] count_q, count_d;

  // Counts handshakes only; flushed instructions never complete one.
  always_comb begin
    count_d = count_q;
    if (accept && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, randomized run against a queue-based
// reference model, and an asynchronous mid-stream reset. Define FETCH_PERF_EN to also check fetch_count.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] instruction_address;
  logic [7:0] instruction_data;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halt_request;
  logic       fetch_ready;
  logic       fetch_valid;
  logic [7:0] fetch_instruction;
  logic [7:0] fetch_pc;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  int numCompared;
  int numMismatched;

  fetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .halt_request        (halt_request),
    .fetch_ready         (fetch_ready),
    .fetch_valid         (fetch_valid),
    .fetch_instruction   (fetch_instruction),
    .fetch_pc            (fetch_pc),
    .halted              (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count         (fetch_count)
`endif
  );

  // Instruction memory preloaded with mem[i] = i ^ 8'hA5, combinational read.
  assign instruction_data = instruction_address ^ 8'hA5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       br;
    logic [7:0] tgt;
    logic       hr;
    logic       rdy;
    logic       expValid;
    logic [7:0] expPc;
    logic [7:0] expInstr;
    logic [7:0] expAddr;
    logic       expHalted;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
  } entry_t;

  vec_t vecs[$];

  // Reference model: the output slot is a queue of at most one entry; phase 0=boot, 1=fetching, 2=halted.
  entry_t      mq[$];
  logic [7:0]  mPc;
  int          mPhase;
  int unsigned mCount;

  task automatic modelReset();
    mq.delete();
    mPc    = 8'h00;
    mPhase = 0;
    mCount = 0;
  endtask

  task automatic modelStep(input logic br, input logic [7:0] tgt, input logic hr, input logic rdy);
    entry_t e;
    if (mq.size() != 0 && rdy) begin
      void'(mq.pop_front());
      if (mCount < 65535) mCount++;
    end
    if (mPhase == 0) begin
      if (br) mPc = tgt;
      mPhase = hr ? 2 : 1;
    end else if (mPhase == 1) begin
      if (br) begin
        mq.delete();
        mPc = tgt;
        mPhase = hr ? 2 : 1;
      end else if (hr) begin
        mPhase = 2;
      end else if (mq.size() == 0) begin
        e.pc = mPc;
        e.instr = mPc ^ 8'hA5;
        mq.push_back(e);
        mPc = mPc + 8'd1;
      end
    end else if (br) begin
      mq.delete();
      mPc = tgt;
      mPhase = 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".valid"}, 16'(fetch_valid), 16'(mq.size() != 0));
    checkOutput({tag, ".addr"}, 16'(instruction_address), 16'(mPc));
    checkOutput({tag, ".halted"}, 16'(halted), 16'(mPhase == 2));
    if (mq.size() != 0) begin
      checkOutput({tag, ".pc"}, 16'(fetch_pc), 16'(mq[0].pc));
      checkOutput({tag, ".instr"}, 16'(fetch_instruction), 16'(mq[0].instr));
    end
`ifdef FETCH_PERF_EN
    checkOutput({tag, ".count"}, fetch_count, 16'(mCount));
`endif
  endtask

  // Drives one cycle of inputs, clocks the DUT and advances the model; outputs are sampled 1 after the edge.
  task automatic applyStimulus(input logic br, input logic [7:0] tgt, input logic hr, input logic rdy);
    branch_taken  = br;
    branch_target = tgt;
    halt_request  = hr;
    fetch_ready   = rdy;
    @(posedge clk);
    #1;
    modelStep(br, tgt, hr, rdy);
  endtask

  function automatic void addVec(input logic br, input logic [7:0] tgt, input logic hr, input logic rdy,
                                 input logic ev, input logic [7:0] epc, input logic [7:0] ein,
                                 input logic [7:0] eaddr, input logic eh);
    vec_t v;
    v.br = br; v.tgt = tgt; v.hr = hr; v.rdy = rdy;
    v.expValid = ev; v.expPc = epc; v.expInstr = ein; v.expAddr = eaddr; v.expHalted = eh;
    vecs.push_back(v);
  endfunction

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    halt_request  = 1'b0;
    fetch_ready   = 1'b1;
    modelReset();

    // Directed scenario: boot, stall at pc 5, redirect over pending pc 7, wrap at FF, halt and restart.
    addVec(0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h00, 8'hA5, 8'h01, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h01, 8'hA4, 8'h02, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h02, 8'hA7, 8'h03, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h03, 8'hA6, 8'h04, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h04, 8'hA1, 8'h05, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h05, 8'hA0, 8'h06, 0);
    for (int i = 0; i < 3; i++) addVec(0, 8'h00, 0, 0, 1, 8'h05, 8'hA0, 8'h06, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h06, 8'hA3, 8'h07, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h07, 8'hA2, 8'h08, 0);
    addVec(1, 8'h40, 0, 0, 0, 8'h00, 8'h00, 8'h40, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h40, 8'hE5, 8'h41, 0);
    addVec(1, 8'hFE, 0, 1, 0, 8'h00, 8'h00, 8'hFE, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'hFE, 8'h5B, 8'hFF, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'hFF, 8'h5A, 8'h00, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h00, 8'hA5, 8'h01, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h01, 8'hA4, 8'h02, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h02, 8'hA7, 8'h03, 0);
    addVec(0, 8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h03, 1);
    addVec(0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h03, 1);
    addVec(1, 8'h10, 0, 1, 0, 8'h00, 8'h00, 8'h10, 0);
    addVec(0, 8'h00, 0, 1, 1, 8'h10, 8'hB5, 8'h11, 0);

    #2;
    checkOutput("reset.valid", 16'(fetch_valid), 16'h0);
    checkOutput("reset.addr", 16'(instruction_address), 16'h00);
    checkOutput("reset.halted", 16'(halted), 16'h0);
    checkOutput("reset.pc", 16'(fetch_pc), 16'h00);
    checkOutput("reset.instr", 16'(fetch_instruction), 16'h00);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    modelReset();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].br, vecs[i].tgt, vecs[i].hr, vecs[i].rdy);
      checkOutput($sformatf("vec%0d.valid", i), 16'(fetch_valid), 16'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.addr", i), 16'(instruction_address), 16'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d.halted", i), 16'(halted), 16'(vecs[i].expHalted));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d.pc", i), 16'(fetch_pc), 16'(vecs[i].expPc));
        checkOutput($sformatf("vec%0d.instr", i), 16'(fetch_instruction), 16'(vecs[i].expInstr));
      end
    end
`ifdef FETCH_PERF_EN
    checkOutput("vec.count", fetch_count, 16'(mCount));
`endif

    for (int i = 0; i < 600; i++) begin
      logic br, hr, rdy;
      logic [7:0] tgt;
      br  = ($urandom % 8) == 0;
      hr  = ($urandom % 16) == 0;
      rdy = ($urandom % 4) != 0;
      tgt = 8'($urandom);
      applyStimulus(br, tgt, hr, rdy);
      checkModel("rand");
    end

    // Stream, then drop rst_n between clock edges and check the outputs clear without a clock.
    applyStimulus(1, 8'h20, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 8'h00, 0, 1);
      checkModel("stream");
    end
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async.valid", 16'(fetch_valid), 16'h0);
    checkOutput("async.addr", 16'(instruction_address), 16'h00);
    checkOutput("async.halted", 16'(halted), 16'h0);
`ifdef FETCH_PERF_EN
    checkOutput("async.count", fetch_count, 16'h0);
`endif
    #12 rst_n = 1'b1;
    modelReset();
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("restart1.valid", 16'(fetch_valid), 16'h0);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("restart2.valid", 16'(fetch_valid), 16'h1);
    checkOutput("restart2.pc", 16'(fetch_pc), 16'h00);
    checkOutput("restart2.instr", 16'(fetch_instruction), 16'hA5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0, 1);
      checkModel("restart");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage directly upstream of the instruction memory.
- Drives instruction_address and captures the returned instruction_data into an output register.
- Presents each instruction with its PC to decode over a valid/ready handshake.
- Handles stall, branch redirect with flush, and halt/restart.

Parameters:
- ADDR_WIDTH, 8, width of the PC and of instruction_address.
- INSTR_WIDTH, 8, width of the instruction word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instruction_address  output  ADDR_WIDTH  address to instruction memory; equals the pc register.
- instruction_data  input  INSTR_WIDTH  memory read data; combinational, valid in the same cycle as instruction_address.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  ADDR_WIDTH  redirect PC; sampled when branch_taken=1.
- halt_request  input  1  stop fetching after the current cycle.
- fetch_ready  input  1  decode accepts fetch_instruction this cycle.
- fetch_valid  output  1  fetch_instruction and fetch_pc hold a valid instruction.
- fetch_instruction  output  INSTR_WIDTH  registered instruction to decode.
- fetch_pc  output  ADDR_WIDTH  address from which fetch_instruction was read.
- halted  output  1  high while the state is HALTED.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - pc = RESET_PC, so instruction_address = RESET_PC.
  - fetch_valid = 0, fetch_instruction = 0, fetch_pc = 0, halted = 0, state = BOOT.
- Reset asserted mid-operation clears all of the above immediately, regardless of clk.
- Definitions:
  - accept = fetch_valid & fetch_ready.
  - slot_free = !fetch_valid | fetch_ready.
- States: BOOT, FETCH, HALTED.
  - BOOT: one cycle, no capture. Next state is FETCH, or HALTED if halt_request=1. branch_taken in BOOT loads pc <= branch_target.
  - FETCH, evaluated in priority order:
    1. branch_taken: pc <= branch_target, fetch_valid <= 0 (flush, even if unaccepted), no capture. State goes to HALTED if halt_request=1, else stays FETCH.
    2. halt_request (no branch): no capture, pc holds, state <= HALTED. fetch_valid <= 0 if accept, else it holds.
    3. slot_free: fetch_instruction <= instruction_data, fetch_pc <= pc, fetch_valid <= 1, pc <= pc+1.
    4. otherwise (stall: fetch_valid=1, fetch_ready=0): pc, fetch_instruction and fetch_pc all hold.
  - HALTED:
    - halted=1; no capture.
    - A pending fetch_valid stays until accepted, then drops to 0.
    - branch_taken: pc <= branch_target, fetch_valid <= 0, state <= FETCH (restart path).
    - halt_request while HALTED has no effect.
- Latency and throughput:
  - The instruction at address A appears on fetch_instruction one cycle after instruction_address=A with slot_free.
  - Back-to-back accepts sustain one instruction per cycle.
  - First fetch_valid appears 2 cycles after rst_n deassertion.
  - The first instruction after a redirect is valid 1 cycle after the branch_taken cycle.
- Arithmetic: pc+1 is modulo 2^ADDR_WIDTH, so 8'hFF increments to 8'h00 with no flag. branch_target is used unmodified.
- fetch_instruction and fetch_pc are stable whenever fetch_valid=1 and fetch_ready=0.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds output fetch_count [15:0], reset 0.
  - Increments on every accept; saturates at 16'hFFFF.
  - Flushed (unaccepted) instructions are not counted.
- Undefined: the fetch_count port and its counter are absent; all other behaviour is identical.

Test Plan:
- Memory preloaded mem[i]=i^8'hA5, fetch_ready=1, release reset:
  - fetch_valid rises on the 2nd clk.
  - Consecutive accepts give fetch_pc 0,1,2,… and fetch_instruction A5,A4,A7,….
- Hold fetch_ready=0 for 3 cycles while fetch_pc=5:
  - fetch_pc=5 and instruction_address=6 stay constant.
  - After release the next accepts are pc 5 then 6; no skip or duplicate.
- branch_taken=1, branch_target=8'h40 while an unaccepted instruction (pc 7) is pending:
  - fetch_valid=0 next cycle.
  - The following cycle gives fetch_pc=8'h40 with fetch_instruction=mem[8'h40].
- Branch to 8'hFE with fetch_ready=1:
  - Accepted sequence is pc FE, FF, 00, 01 with correct data.
- halt_request pulse at pc 3, then branch_taken to 8'h10 two cycles later:
  - halted=1 and no pc 3 fetch.
  - Resume at 8'h10; halted=0.
- Assert rst_n=0 between clock edges during streaming:
  - Outputs clear immediately: fetch_valid=0, instruction_address=RESET_PC.
  - Restart timing as in the first scenario.
  - With FETCH_PERF_EN, fetch_count=0 after reset and equals the accept count otherwise.
